// File: rtl/sort_result_drain_pkg.sv
// Shared definitions for the sort result drain.
//   OUTPUT_BUF_DATASIZE : element width of the softmax output buffer
//   SORT_NUM_PE         : default number of sort PEs (2 elements per PE)
//   sd_state_t          : drain FSM state encoding
package sort_result_drain_pkg;

  localparam int OUTPUT_BUF_DATASIZE = 32;
  localparam int SORT_NUM_PE         = 8;

  typedef enum logic {
    SD_IDLE   = 1'b0,
    SD_STREAM = 1'b1
  } sd_state_t;

endpackage

// File: rtl/sort_result_drain.sv
// Reader side of the systolic odd-even sort array. Snapshots the PE
// contents on sort_done, then streams the first k elements (ascending
// or descending) over a valid/ready handshake.
//
// state     | meaning
// ----------+------------------------------------------------------
// SD_IDLE   | waiting for sort_done; a k=0 capture pulses drain_done
// SD_STREAM | snapshot held, emitting one element per handshake
//
// Ports:
//   clk, rst          clock, async active-low reset
//   sort_done         array contents final this cycle (pulse)
//   array_data        concatenated PE contents, element i at i*DATA_W
//   top_k, descending drain length and order, sampled with sort_done
//   flush             synchronous abort of the current drain
//   m_valid/m_ready   output handshake
//   m_data, m_index   element value and array position
//   m_last            final element of the drain
//   busy              drain in progress
//   drain_done        pulse after the final handshake or a k=0 capture
//   overrun           sticky: sort_done arrived while busy
module sort_result_drain
  import sort_result_drain_pkg::*;
#(
  parameter int NUM_PE = SORT_NUM_PE,
  parameter int DATA_W = OUTPUT_BUF_DATASIZE,
  parameter int IDX_W  = $clog2(2*NUM_PE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sort_done,
  input  logic [2*NUM_PE*DATA_W-1:0] array_data,
  input  logic [IDX_W:0]             top_k,
  input  logic                       descending,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [IDX_W-1:0]           m_index,
  output logic                       m_last,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       overrun
);

  localparam int N  = 2*NUM_PE;
  localparam int KW = IDX_W + 1;
  localparam logic [KW-1:0]    LP_N       = KW'(N);
  localparam logic [KW-1:0]    LP_ONE     = KW'(1);
  localparam logic [IDX_W-1:0] LP_TOP     = IDX_W'(N-1);
  localparam logic [IDX_W-1:0] LP_IDX_ONE = IDX_W'(1);

  sd_state_t            r_state;
  sd_state_t            w_state_nxt;
  logic [N*DATA_W-1:0]  r_snap;
  logic                 r_desc;
  logic [KW-1:0]        r_k;
  logic [KW-1:0]        r_cnt;
  logic [IDX_W-1:0]     r_index;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_done;
  logic                 r_overrun;

  logic [KW-1:0]        w_k_eff;
  logic [IDX_W-1:0]     w_start;
  logic [IDX_W-1:0]     w_step;
  logic [KW-1:0]        w_cnt_nxt;
  logic                 w_hs;
  logic                 w_final;

  assign w_k_eff   = (top_k > LP_N) ? LP_N : top_k;
  assign w_start   = descending ? LP_TOP : '0;
  assign w_step    = r_desc ? (r_index - LP_IDX_ONE) : (r_index + LP_IDX_ONE);
  assign w_cnt_nxt = r_cnt + LP_ONE;
  assign w_hs      = r_valid & m_ready;
  assign w_final   = w_hs & r_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SD_IDLE:   if (sort_done && (w_k_eff != '0)) w_state_nxt = SD_STREAM;
      SD_STREAM: if (w_final) w_state_nxt = SD_IDLE;
      default:   w_state_nxt = SD_IDLE;
    endcase
    if (flush) w_state_nxt = SD_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SD_IDLE;
    else      r_state <= w_state_nxt;
  end

  // m_data/m_index/m_last are loaded one step ahead so they stay
  // registered and only move on a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap    <= '0;
      r_desc    <= 1'b0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_index   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        case (r_state)
          SD_IDLE: begin
            if (sort_done) begin
              r_snap <= array_data;
              r_desc <= descending;
              r_k    <= w_k_eff;
              r_cnt  <= '0;
              if (w_k_eff == '0) begin
                r_done <= 1'b1;
              end else begin
                r_valid <= 1'b1;
                r_index <= w_start;
                r_data  <= array_data[w_start*DATA_W +: DATA_W];
                r_last  <= (w_k_eff == LP_ONE);
              end
            end
          end
          SD_STREAM: begin
            // Includes sort_done coinciding with the final handshake.
            if (sort_done) r_overrun <= 1'b1;
            if (w_hs) begin
              if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_cnt   <= w_cnt_nxt;
                r_index <= w_step;
                r_data  <= r_snap[w_step*DATA_W +: DATA_W];
                r_last  <= (w_cnt_nxt == (r_k - LP_ONE));
              end
            end
          end
          default: r_valid <= 1'b0;
        endcase
      end
    end
  end

  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign m_index    = r_index;
  assign m_last     = r_last;
  assign busy       = (r_state == SD_STREAM);
  assign drain_done = r_done;
  assign overrun    = r_overrun;

endmodule

// File: doc/sort_result_drain.md
Name: sort_result_drain

Overview:
- Reader side of the systolic odd-even sort array in the softmax path.
- The sort PEs are loaded in parallel and sort in place. This block snapshots the concatenated PE contents once sorting finishes.
- It then streams the first top_k elements out one per cycle over a valid/ready handshake toward the softmax output buffer.
- Order is selectable: ascending, or descending (largest first).

Parameters:
- NUM_PE, 8: number of sort PEs in the array; each PE holds 2 elements, so N = 2*NUM_PE elements.
- DATA_W, `OUTPUT_BUF_DATASIZE (32): element width.
- IDX_W, $clog2(2*NUM_PE): element index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; when low, all state clears immediately.
- sort_done  in  1  single-cycle pulse: array contents are final this cycle.
- array_data  in  2*NUM_PE*DATA_W  concatenation of each PE's {num2,num1}. PE0 is at the LSBs, so element i = array_data[i*DATA_W +: DATA_W].
- top_k  in  IDX_W+1  number of elements to emit; sampled with sort_done.
- descending  in  1  1 = emit from element N-1 downward; sampled with sort_done.
- flush  in  1  synchronous abort of the current drain.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  element value.
- m_index  out  IDX_W  array position of m_data.
- m_last  out  1  high with the final element of the drain.
- busy  out  1  snapshot held, drain in progress.
- drain_done  out  1  one-cycle pulse after the final handshake, or after a k=0 capture.
- overrun  out  1  sticky: sort_done arrived while busy.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; snapshot register and counters cleared.
  - m_valid, m_data, m_index, m_last, busy, drain_done and overrun all 0.
- State machine, IDLE -> STREAM -> IDLE:
  - IDLE + sort_done: capture array_data, top_k and descending into registers.
    - k_eff = min(top_k, N).
    - If k_eff = 0: pulse drain_done next cycle and stay in IDLE.
    - Otherwise go to STREAM; busy and m_valid go high the next cycle. Latency from sort_done to first valid is 1 cycle.
  - STREAM: m_data = snapshot element at pointer p, and m_index = p.
    - Start value: p = 0 when ascending, p = N-1 when descending.
    - On each handshake (m_valid & m_ready): emitted count increments; p steps +1 (ascending) or -1 (descending).
    - m_last = (emitted count == k_eff-1).
    - Handshake with m_last: m_valid, busy and m_last drop next cycle, drain_done pulses that same cycle, return to IDLE.
- Handshake rules:
  - m_valid, m_data, m_index and m_last are registered and stay stable while m_valid & !m_ready.
  - One element per cycle when m_ready is held high, so k_eff elements take exactly k_eff cycles.
  - m_valid never depends combinationally on m_ready.
- sort_done while busy: ignored; the snapshot is unchanged and overrun is set (sticky until rst).
- sort_done in the same cycle as the final handshake: treated as busy, so overrun is set and the new data is not captured.
- flush: takes priority over everything. Next cycle the block is in IDLE with m_valid = 0 and busy = 0; no drain_done pulse; overrun is kept.
- Reset mid-stream: outputs clear immediately; no partial drain_done.
- Pointer never wraps: a descending drain with k_eff = N ends at p = 0, an ascending one at p = N-1.
- top_k > N is clamped to N and no error is raised.

Decomposition:
- DATA_W comes from the existing `OUTPUT_BUF_DATASIZE define in config.v.
- Add to config.v: `SORT_NUM_PE, and the state encodings SD_IDLE and SD_STREAM.
- No sub-module: the snapshot register plus an indexed mux stays in one file.
- Optional sub-module: sort_drain_mux (N:1 element select by p) if the timing report demands pipelining. That would add 1 cycle of latency and is not in the baseline.

Test Plan:
- Ascending full drain: NUM_PE=4; elements 0..7 = 1,2,3,4,5,6,7,8; top_k=8, descending=0, m_ready=1 → 8 consecutive valids with data 1..8 and index 0..7; m_last on data 8; drain_done the cycle after.
- Descending top-3 with backpressure: same data, top_k=3, descending=1, m_ready toggling 1,0,1,0 → data 8,7,6 and index 7,6,5; output stable during ready-low cycles; m_last on 6.
- k=0 and clamp:
  - top_k=0 → no m_valid; drain_done 1 cycle after sort_done.
  - top_k=15 with N=8 → exactly 8 elements.
- Overrun: a second sort_done carrying different data during the drain → stream continues with the original values; overrun=1 persists after drain_done.
- Flush at the 3rd element: m_valid=0 and busy=0 next cycle; no drain_done; a new sort_done is then accepted normally.
- Async reset mid-stream: rst low between clock edges → m_valid, busy and overrun read 0 before the next clk edge; after release, IDLE with no output.
